// File: rtl/ro_freq_meter_pkg.sv
// ---------------------------------------------------------------------------
// ro_freq_meter_pkg : shared FSM encoding, timing constants and gate helper. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ro_freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_GATE = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int ARM_CYCLES = 3;
  localparam int GATE_BASE  = 256;
  localparam int GATE_W     = 16;

  // Window length in clk cycles; the largest window (256<<7) still fits GATE_W bits.
  function automatic logic [GATE_W-1:0] gate_len(input logic [2:0] gate_sel);
    return GATE_W'(GATE_BASE) << gate_sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ro_channel.sv
// ---------------------------------------------------------------------------
// ro_channel : one ring oscillator (or external source) driving a free-running prescaler. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ro_channel #(
  parameter int DEPTH         = 12,
  parameter int PRESCALE_BITS = 4,
  parameter int USE_EXT_OSC   = 0
) (
  input  logic rst_n,
  input  logic ena,
  input  logic ext_osc,
  output logic msb
);

  logic                     w_src;
  logic [PRESCALE_BITS-1:0] r_prescale;

  generate
    if (USE_EXT_OSC != 0) begin : g_ext
      assign w_src = ext_osc;
    end else begin : g_ring_osc
      localparam int STAGES = 2 * DEPTH + 1;
      logic [STAGES-1:0] w_node;
      logic              w_unused_ext;

      assign w_unused_ext = ext_osc;
      // The head stage is a NAND so that ena low parks the ring in a static state.
      assign w_node[0] = ~(w_node[STAGES-1] & ena);
      for (genvar k = 1; k < STAGES; k++) begin : g_inv
        assign w_node[k] = ~w_node[k-1];
      end
      assign w_src = w_node[STAGES-1];
    end
  endgenerate

  always_ff @(posedge w_src or negedge rst_n) begin
    if (!rst_n) begin
      r_prescale <= '0;
    end else if (ena) begin
      r_prescale <= r_prescale + PRESCALE_BITS'(1);
    end
  end

  assign msb = r_prescale[PRESCALE_BITS-1];

endmodule

`default_nettype wire

// File: rtl/ro_freq_meter.sv
// ---------------------------------------------------------------------------
// ro_freq_meter : ring-oscillator bank with gated edge-count frequency meter.
// Optional continuous re-arm: RO_FREQ_METER_CONT_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ro_freq_meter
  import ro_freq_meter_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int DEPTH_BASE    = 12,
  parameter int PRESCALE_BITS = 4,
  parameter int COUNT_W       = 16,
  parameter int USE_EXT_OSC   = 0,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [NUM_CH-1:0]  ext_osc,
  input  logic               start,
  input  logic [CH_W-1:0]    ch_sel,
  input  logic [2:0]         gate_sel,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [COUNT_W-1:0] count,
  output logic               osc_mon
);

  localparam int                CH_SPAN  = 1 << CH_W;
  localparam logic [CH_SPAN-1:0] CH_VALID = {CH_SPAN{1'b1}} >> (CH_SPAN - NUM_CH);

  state_t              r_state;
  state_t              w_next;
  logic [CH_SPAN-1:0]  w_msb;
  logic [CH_W-1:0]     r_ch;
  logic [2:0]          r_gate_sel;
  logic [1:0]          r_arm_cnt;
  logic [GATE_W-1:0]   r_gate_cnt;
  logic [COUNT_W-1:0]  r_count;
  logic                r_overflow;
  logic                r_sync1, r_sync2, r_sync3;
  logic                w_edge, w_accept, w_rearm, w_abort;

  // Channels are padded to a power of two so the mux index never runs off the end.
  generate
    for (genvar i = 0; i < CH_SPAN; i++) begin : g_ch
      if (i < NUM_CH) begin : g_inst
        ro_channel #(
          .DEPTH         (DEPTH_BASE << i),
          .PRESCALE_BITS (PRESCALE_BITS),
          .USE_EXT_OSC   (USE_EXT_OSC)
        ) u_ch (
          .rst_n   (rst_n),
          .ena     (ena),
          .ext_osc (ext_osc[i]),
          .msb     (w_msb[i])
        );
      end else begin : g_pad
        assign w_msb[i] = 1'b0;
      end
    end
  endgenerate

  assign w_edge   = r_sync2 & ~r_sync3;
  assign w_accept = (r_state == ST_IDLE) && start && ena && CH_VALID[ch_sel];
  assign w_abort  = ((r_state == ST_ARM) || (r_state == ST_GATE)) && !ena;
`ifdef RO_FREQ_METER_CONT_EN
  assign w_rearm  = (r_state == ST_DONE) && start && ena;
`else
  assign w_rearm  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_ARM;
      ST_ARM:  if (!ena) w_next = ST_IDLE;
               else if (r_arm_cnt == 2'd0) w_next = ST_GATE;
      ST_GATE: if (!ena) w_next = ST_IDLE;
               else if (r_gate_cnt == '0) w_next = ST_DONE;
      ST_DONE: w_next = w_rearm ? ST_ARM : ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == ST_ARM) || (r_state == ST_GATE);
    done = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_sync3    <= 1'b0;
      r_ch       <= '0;
      r_gate_sel <= 3'd0;
      r_arm_cnt  <= 2'd0;
      r_gate_cnt <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_sync1 <= w_msb[r_ch];
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      if (w_accept) begin
        r_ch       <= ch_sel;
        r_gate_sel <= gate_sel;
      end
      if (w_accept || w_rearm) begin
        r_count    <= '0;
        r_overflow <= 1'b0;
        r_arm_cnt  <= 2'(ARM_CYCLES - 1);
      end else if (w_abort) begin
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else begin
        case (r_state)
          ST_ARM: begin
            r_arm_cnt  <= r_arm_cnt - 2'd1;
            r_gate_cnt <= gate_len(r_gate_sel) - GATE_W'(1);
          end
          ST_GATE: begin
            r_gate_cnt <= r_gate_cnt - GATE_W'(1);
            // Saturate rather than wrap; overflow marks edges lost at full scale.
            if (w_edge) begin
              if (&r_count) r_overflow <= 1'b1;
              else          r_count    <= r_count + COUNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign count    = r_count;
  assign overflow = r_overflow;
  assign osc_mon  = w_msb[r_ch];

endmodule

`default_nettype wire

// File: tb/tb_ro_freq_meter.sv
// ---------------------------------------------------------------------------
// tb_ro_freq_meter : scoreboard bench for ro_freq_meter using external sources. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ro_freq_meter;

  typedef struct {
    int lo;
    int hi;
    int ovf;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic [3:0]  ext_osc = 4'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [1:0]  ch_sel_a = 2'd0, ch_sel_b = 2'd0;
  logic [2:0]  gate_sel_a = 3'd0, gate_sel_b = 3'd0;
  logic        busy_a, done_a, overflow_a, osc_mon_a;
  logic        busy_b, done_b, overflow_b, osc_mon_b;
  logic [15:0] count_a;
  logic [3:0]  count_b;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_seen_a = 0;
  int   done_seen_b = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  ro_freq_meter #(.NUM_CH(4), .COUNT_W(16), .USE_EXT_OSC(1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ext_osc(ext_osc), .start(start_a),
    .ch_sel(ch_sel_a), .gate_sel(gate_sel_a), .busy(busy_a), .done(done_a),
    .overflow(overflow_a), .count(count_a), .osc_mon(osc_mon_a)
  );

  ro_freq_meter #(.NUM_CH(3), .COUNT_W(4), .USE_EXT_OSC(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ext_osc(ext_osc[2:0]), .start(start_b),
    .ch_sel(ch_sel_b), .gate_sel(gate_sel_b), .busy(busy_b), .done(done_b),
    .overflow(overflow_b), .count(count_b), .osc_mon(osc_mon_b)
  );

  // clk period 10; sources deliberately offset from clk edges.
  always #5 clk = ~clk;
  initial forever #7 ext_osc[0] = ~ext_osc[0];
  initial begin #3; forever #10 ext_osc[1] = ~ext_osc[1]; end
  initial begin #4; forever #20 ext_osc[2] = ~ext_osc[2]; end
  initial forever #9 ext_osc[3] = ~ext_osc[3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  always @(negedge clk) begin
    if (done_a) begin
      done_seen_a++;
      if (q_a.size() == 0) begin
        chk("done_a_unexpected", 1, 0);
      end else begin
        e_a = q_a.pop_front();
        chk_range("count_a", int'(count_a), e_a.lo, e_a.hi);
        chk("overflow_a", int'(overflow_a), e_a.ovf);
        chk("latency_a", cyc, e_a.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (done_b) begin
      done_seen_b++;
      if (q_b.size() == 0) begin
        chk("done_b_unexpected", 1, 0);
      end else begin
        e_b = q_b.pop_front();
        chk_range("count_b", int'(count_b), e_b.lo, e_b.hi);
        chk("overflow_b", int'(overflow_b), e_b.ovf);
        chk("latency_b", cyc, e_b.cyc);
      end
    end
  end

  // One-cycle start pulse; done is due 3 arm cycles plus the window after the accept edge.
  task automatic measure_a(input int ch, input int gs, input int lo, input int hi, input int ovf);
    @(negedge clk);
    ch_sel_a = 2'(ch); gate_sel_a = 3'(gs); start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("accept_busy_a", int'(busy_a), 1);
    chk("accept_clear_a", int'(count_a), 0);
    q_a.push_back('{lo, hi, ovf, cyc + 3 + (256 << gs)});
  endtask

  task automatic measure_b(input int ch, input int gs, input int lo, input int hi, input int ovf);
    @(negedge clk);
    ch_sel_b = 2'(ch); gate_sel_b = 3'(gs); start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("accept_busy_b", int'(busy_b), 1);
    q_b.push_back('{lo, hi, ovf, cyc + 3 + (256 << gs)});
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: pending %0d/%0d expected 0/0", q_a.size(), q_b.size());
      q_a.delete();
      q_b.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    #1;
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_overflow", int'(overflow_a), 0);
    chk("rst_count", int'(count_a), 0);
    chk("rst_osc_mon", int'(osc_mon_a), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // clk/2 source: 256 cycles -> 128 edges / 16 = 8; start and selects toggled mid-run.
    measure_a(1, 0, 7, 9, 0);
    repeat (20) @(negedge clk);
    ch_sel_a = 2'd2; gate_sel_a = 3'd3; start_a = 1'b1;
    repeat (2) @(negedge clk);
    start_a = 1'b0;
    wait_drain(400);
    chk("single_done_t1", done_seen_a, 1);

    // clk/4 source over 1024 cycles -> 16.
    measure_a(2, 2, 15, 17, 0);
    wait_drain(1200);

    // Out-of-range channel on a 3-channel instance is ignored.
    @(negedge clk);
    ch_sel_b = 2'd3; start_b = 1'b1;
    repeat (5) @(negedge clk);
    start_b = 1'b0;
    chk("bad_ch_ignored", int'(busy_b), 0);

    // 4-bit counter saturates: 2048 cycles at clk/2 gives 64 prescaled edges.
    measure_b(1, 3, 15, 15, 1);
    wait_drain(2200);
    chk("single_done_sat", done_seen_b, 1);

    // ena dropped in GATE cycle 100 aborts without done.
    seen = done_seen_a;
    measure_a(1, 0, 0, 0, 0);
    void'(q_a.pop_back());
    repeat (3 + 99) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_count", int'(count_a), 0);
    chk("abort_overflow", int'(overflow_a), 0);
    repeat (300) @(negedge clk);
    chk("abort_no_done", done_seen_a, seen);
    ena = 1'b1;
    repeat (4) @(negedge clk);

`ifdef RO_FREQ_METER_CONT_EN
    // Held start re-arms every 260 cycles; each window re-cleared.
    @(negedge clk);
    ch_sel_a = 2'd1; gate_sel_a = 3'd0; start_a = 1'b1;
    @(negedge clk);
    q_a.push_back('{7, 9, 0, cyc + 259});
    q_a.push_back('{7, 9, 0, cyc + 259 + 260});
    begin
      int n = 0;
      while (q_a.size() != 0 && n < 700) begin
        @(negedge clk);
        #1;
        n++;
      end
    end
    start_a = 1'b0;
    seen = done_seen_a;
    wait_drain(10);
    repeat (300) @(negedge clk);
    chk("cont_stops", done_seen_a, seen);
`endif

    // Asynchronous reset in the middle of a window clears everything at once.
    measure_a(2, 2, 0, 0, 0);
    void'(q_a.pop_back());
    repeat (600) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy_a), 0);
    chk("midrst_count", int'(count_a), 0);
    chk("midrst_osc_mon", int'(osc_mon_a), 0);
    chk("midrst_count_b", int'(count_b), 0);
    chk("midrst_overflow_b", int'(overflow_b), 0);
    repeat (3) @(negedge clk);
    chk("midrst_prescaler_held", int'(osc_mon_a), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_no_done", int'(busy_a), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
